// File: rtl/vec_pkg.sv
// Shared definitions for the vector datapath.
// Holds the default bank geometry, the element width used by the sequencer and
// the element registers, and the sequencer FSM state encoding.
package vec_pkg;

  localparam int unsigned DEF_NUM_ELEM = 8;
  localparam int unsigned DEF_IDX_W    = 3;
  localparam int unsigned ELEM_W       = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/vector_load_sequencer_if.sv
// Byte-stream valid/ready channel feeding the vector load sequencer.
//   in_valid : producer has a byte on in_data
//   in_ready : consumer accepts the byte this cycle
//   in_data  : stream byte (ELEM_W bits)
// master = stream producer, slave = sequencer.
interface vector_load_sequencer_if;
  import vec_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/idx_onehot_dec.sv
// Combinational IDX_W-to-NUM_ELEM one-hot decoder.
//   idx    : element index
//   onehot : exactly one bit set, at position idx
module idx_onehot_dec #(
  parameter int unsigned NUM_ELEM = 8,
  parameter int unsigned IDX_W    = 3
) (
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_ELEM-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/vector_load_sequencer.sv
// Writes a byte stream into consecutive element registers of a vector bank.
//   clk, reset        : clock, asynchronous active-high reset
//   start             : command strobe, honoured only when idle
//   base_idx, len     : first element and element count, sampled with start
//   busy              : high while loading
//   s (slave)         : in_valid/in_ready/in_data byte stream
//   reg_din, reg_ld   : registered data and one-hot load enables to the bank
//   done              : one-cycle completion pulse, coincident with the last reg_ld
module vector_load_sequencer
  import vec_pkg::*;
#(
  parameter int unsigned NUM_ELEM = DEF_NUM_ELEM,
  parameter int unsigned IDX_W    = DEF_IDX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [IDX_W-1:0]         base_idx,
  input  logic [IDX_W:0]           len,
  output logic                     busy,
  vector_load_sequencer_if.slave   s,
  output logic [ELEM_W-1:0]        reg_din,
  output logic [NUM_ELEM-1:0]      reg_ld,
  output logic                     done
);

  localparam logic [IDX_W:0] MaxRem = (IDX_W + 1)'(NUM_ELEM);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W:0]        rem_q, rem_d;
  logic [ELEM_W-1:0]     din_q, din_d;
  logic [NUM_ELEM-1:0]   ld_q, ld_d;
  logic                  done_q, done_d;
  logic [NUM_ELEM-1:0]   idx_onehot;
  logic                  hs;

  idx_onehot_dec #(
    .NUM_ELEM (NUM_ELEM),
    .IDX_W    (IDX_W)
  ) u_dec (
    .idx    (idx_q),
    .onehot (idx_onehot)
  );

  assign hs = s.in_valid && (state_q == ST_LOAD);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start && (len != '0)) state_d = ST_LOAD;
      ST_LOAD: if (hs && (rem_q == (IDX_W + 1)'(1))) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy       = (state_q == ST_LOAD);
    s.in_ready = (state_q == ST_LOAD);
  end

  // Counter and output-register next values; reg_ld is a pulse so it defaults to 0,
  // while reg_din holds between handshakes.
  always_comb begin
    idx_d  = idx_q;
    rem_d  = rem_q;
    din_d  = din_q;
    ld_d   = '0;
    done_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        if (len == '0) begin
          done_d = 1'b1;
        end else begin
          idx_d = base_idx;
          rem_d = (len > MaxRem) ? MaxRem : len;
        end
      end
    end else if (hs) begin
      din_d  = s.in_data;
      ld_d   = idx_onehot;
      idx_d  = idx_q + IDX_W'(1);  // wraps since NUM_ELEM is a power of two
      rem_d  = rem_q - (IDX_W + 1)'(1);
      done_d = (rem_q == (IDX_W + 1)'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      rem_q  <= '0;
      din_q  <= '0;
      ld_q   <= '0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      rem_q  <= rem_d;
      din_q  <= din_d;
      ld_q   <= ld_d;
      done_q <= done_d;
    end
  end

  assign reg_din = din_q;
  assign reg_ld  = ld_q;
  assign done    = done_q;

endmodule

// File: tb/tb_vector_load_sequencer.sv
module tb_vector_load_sequencer;
  import vec_pkg::*;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] base_idx = '0;
  logic [3:0] len = '0;
  logic       busy;
  logic [7:0] reg_din;
  logic [7:0] reg_ld;
  logic       done;

  vector_load_sequencer_if sif ();

  vector_load_sequencer #(
    .NUM_ELEM (N),
    .IDX_W    (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_idx (base_idx),
    .len      (len),
    .busy     (busy),
    .s        (sif),
    .reg_din  (reg_din),
    .reg_ld   (reg_ld),
    .done     (done)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] ld;
    logic [7:0] din;
    bit         done;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] bank[N];
  logic [7:0] exp_bank[N];
  logic [7:0] data_buf[N];
  logic [7:0] last_din = 8'h00;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Element bank as it would sit in the datapath
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) bank[i] <= 8'h00;
    end else begin
      for (int i = 0; i < N; i++) if (reg_ld[i]) bank[i] <= reg_din;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse on reg_ld/done must match the head of the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (reg_ld != 8'h00 || done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: got ld=0x%0h done=%0b expected no pulse (cycle %0d)",
                   reg_ld, done, cyc);
        end else begin
          e = sb.pop_front();
          chk("reg_ld", {24'h0, reg_ld}, {24'h0, e.ld});
          chk("reg_din", {24'h0, reg_din}, {24'h0, e.din});
          chk("done", {31'h0, done}, {31'h0, e.done});
          chk("pulse_cycle", cyc, e.cyc);
          chk("busy_vs_done", {31'h0, busy}, {31'h0, !e.done});
        end
      end
      chk("ld_onehot", {31'h0, ($countones(reg_ld) <= 1)}, 32'h1);
    end
  end

  task automatic clear_model();
    for (int i = 0; i < N; i++) exp_bank[i] = 8'h00;
    last_din = 8'h00;
    sb.delete();
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < N; i++) chk(tag, {24'h0, bank[i]}, {24'h0, exp_bank[i]});
  endtask

  // Issue one command. stall_at: stall 2 cycles before byte k==stall_at;
  // stop_after: stop feeding after that many bytes (-1 = feed all).
  task automatic run_cmd(input int base, input int l, input int stall_at, input bit rand_stall,
                         input bit poke, input int stop_after);
    int n, k, stalls, slot;
    bit stall;
    n = (l > N) ? N : l;
    @(negedge clk);
    start    = 1'b1;
    base_idx = base[2:0];
    len      = l[3:0];
    if (n == 0) sb.push_back('{8'h00, last_din, 1'b1, cyc + 1});
    @(negedge clk);
    start = 1'b0;
    k = 0;
    stalls = 0;
    while (k < n && k != stop_after) begin
      stall = (k == stall_at && stalls < 2) || (rand_stall && $urandom_range(0, 3) == 0);
      if (k == stall_at && stalls < 2) stalls++;
      chk("busy_in_load", {31'h0, busy}, 32'h1);
      chk("in_ready_in_load", {31'h0, sif.in_ready}, 32'h1);
      start    = poke && (k == 1);
      base_idx = base[2:0] + 3'd3;
      if (stall) begin
        sif.in_valid = 1'b0;
      end else begin
        sif.in_valid = 1'b1;
        sif.in_data  = data_buf[k];
        slot = (base + k) % N;
        sb.push_back('{8'(1 << slot), data_buf[k], (k == n - 1), cyc + 1});
        exp_bank[slot] = data_buf[k];
        last_din       = data_buf[k];
      end
      @(negedge clk);
      if (!stall) k++;
    end
    sif.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    sif.in_valid = 1'b0;
    sif.in_data  = 8'h00;
    clear_model();
    // Reset then idle
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_in_ready", {31'h0, sif.in_ready}, 0);
    chk("rst_reg_din", {24'h0, reg_din}, 0);
    chk("rst_reg_ld", {24'h0, reg_ld}, 0);
    chk("rst_done", {31'h0, done}, 0);
    sif.in_valid = 1'b1;
    sif.in_data  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", {31'h0, sif.in_ready}, 0);
      chk("idle_reg_ld", {24'h0, reg_ld}, 0);
    end
    sif.in_valid = 1'b0;

    // Basic load
    data_buf[0] = 8'h11; data_buf[1] = 8'h22; data_buf[2] = 8'h33;
    run_cmd(0, 3, -1, 1'b0, 1'b0, -1);
    drain();
    check_bank("bank_basic");

    // Wrap and stall
    data_buf[0] = 8'hA0; data_buf[1] = 8'hA1; data_buf[2] = 8'hA2; data_buf[3] = 8'hA3;
    run_cmd(6, 4, 2, 1'b0, 1'b0, -1);
    drain();
    check_bank("bank_wrap");

    // Clipping
    for (int i = 0; i < N; i++) data_buf[i] = 8'(8'hC0 + i);
    run_cmd(3, 9, -1, 1'b0, 1'b0, -1);
    drain();
    check_bank("bank_clip");

    // Zero length
    run_cmd(5, 0, -1, 1'b0, 1'b0, -1);
    drain();

    // Start while loading is ignored
    for (int i = 0; i < 5; i++) data_buf[i] = 8'(8'h70 + i);
    run_cmd(2, 5, -1, 1'b0, 1'b1, -1);
    drain();
    check_bank("bank_poke");

    // Reset after 2 of 5 bytes
    for (int i = 0; i < 5; i++) data_buf[i] = 8'(8'hE0 + i);
    run_cmd(1, 5, -1, 1'b0, 1'b0, 2);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, busy}, 0);
    chk("midrst_in_ready", {31'h0, sif.in_ready}, 0);
    chk("midrst_reg_ld", {24'h0, reg_ld}, 0);
    chk("midrst_reg_din", {24'h0, reg_din}, 0);
    chk("midrst_done", {31'h0, done}, 0);
    chk("midrst_sb_empty", sb.size(), 0);
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    data_buf[0] = 8'h5A; data_buf[1] = 8'hA5;
    run_cmd(7, 2, -1, 1'b0, 1'b0, -1);
    drain();
    check_bank("bank_after_rst");

    // Randomised commands with random stalls and stray starts
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N; i++) data_buf[i] = 8'($urandom);
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 10)), -1, 1'b1,
              1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 1) == 1) repeat (int'($urandom_range(1, 3))) @(negedge clk);
    end
    drain();
    check_bank("bank_random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of stimulus");
    $fatal(1, "timeout");
  end

endmodule
